// File: rtl/wb_queue.sv
// Writeback queue: two producers (mem, alu) into an in-order FIFO retiring one entry per cycle
// onto the A/D bank write ports. Define WBQ_BYPASS_EN to let results skip an empty queue.
module wb_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic                     mem_bank,
    input  logic [2:0]               mem_addr,
    input  logic [47:0]              mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic                     alu_bank,
    input  logic [2:0]               alu_addr,
    input  logic [47:0]              alu_data,
    output logic                     weA,
    output logic [2:0]               waddrA,
    output logic [47:0]              wdataA,
    output logic                     weD,
    output logic [2:0]               waddrD,
    output logic [47:0]              wdataD,
    output logic [7:0]               pendA,
    output logic [7:0]               pendD,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic        bank;
        logic [2:0]  addr;
        logic [47:0] data;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic [CW-1:0]   w_free;
    logic            w_mem_fire;
    logic            w_alu_fire;
    logic            w_deq;
    logic            w_byp_mem;
    logic            w_byp_alu;
    logic            w_enq_mem;
    logic            w_enq_alu;
    logic            w_out_valid;
    entry_t          w_out;
    entry_t          w_mem_ent;
    entry_t          w_alu_ent;
    logic [AW-1:0]   w_off;
    logic [AW-1:0]   w_idx;

    assign w_free    = CW'(DEPTH) - r_count;
    assign mem_ready = !rst && (w_free >= CW'(1));
    assign alu_ready = !rst && ((w_free >= CW'(2)) || ((w_free >= CW'(1)) && !mem_valid));

    assign w_mem_fire = mem_valid && mem_ready;
    assign w_alu_fire = alu_valid && alu_ready;
    assign w_deq      = !rst && (r_count != '0);
    assign w_mem_ent  = '{bank: mem_bank, addr: mem_addr, data: mem_data};
    assign w_alu_ent  = '{bank: alu_bank, addr: alu_addr, data: alu_data};

`ifdef WBQ_BYPASS_EN
    // Empty queue: the older result goes straight to the bank, any second one is queued.
    assign w_byp_mem = (r_count == '0) && w_mem_fire;
    assign w_byp_alu = (r_count == '0) && w_alu_fire && !w_mem_fire;
`else
    assign w_byp_mem = 1'b0;
    assign w_byp_alu = 1'b0;
`endif

    assign w_enq_mem   = w_mem_fire && !w_byp_mem;
    assign w_enq_alu   = w_alu_fire && !w_byp_alu;
    assign w_out_valid = w_deq || w_byp_mem || w_byp_alu;
    assign w_out       = w_deq ? r_mem[r_head] : (w_byp_mem ? w_mem_ent : w_alu_ent);

    always_comb begin
        weA    = 1'b0;
        waddrA = '0;
        wdataA = '0;
        weD    = 1'b0;
        waddrD = '0;
        wdataD = '0;
        if (w_out_valid) begin
            if (w_out.bank) begin
                weD    = 1'b1;
                waddrD = w_out.addr;
                wdataD = w_out.data;
            end else if (w_out.addr != 3'd0) begin
                weA    = 1'b1;
                waddrA = w_out.addr;
                wdataA = w_out.data;
            end
        end
    end

    always_comb begin
        pendA = '0;
        pendD = '0;
        w_off = '0;
        w_idx = '0;
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                w_idx = AW'(i);
                w_off = w_idx - r_head;
                if ({1'b0, w_off} < r_count) begin
                    if (r_mem[w_idx].bank)
                        pendD[r_mem[w_idx].addr] = 1'b1;
                    else if (r_mem[w_idx].addr != 3'd0)
                        pendA[r_mem[w_idx].addr] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_deq);
            r_tail  <= r_tail + AW'(w_enq_mem) + AW'(w_enq_alu);
            r_count <= r_count + CW'(w_enq_mem) + CW'(w_enq_alu) - CW'(w_deq);
        end
    end

    // Storage needs no reset; fire signals are already gated by rst via the readies.
    always_ff @(posedge clk) begin
        if (w_enq_mem)
            r_mem[r_tail] <= w_mem_ent;
        if (w_enq_alu)
            r_mem[r_tail + AW'(w_enq_mem)] <= w_alu_ent;
    end

    assign count = r_count;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus random traffic against a
// queue-based reference model; honours WBQ_BYPASS_EN when defined.
module tb_wb_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0, mem_bank = 1'b0, alu_valid = 1'b0, alu_bank = 1'b0;
    logic [2:0]  mem_addr = '0, alu_addr = '0;
    logic [47:0] mem_data = '0, alu_data = '0;
    logic        mem_ready, alu_ready, weA, weD;
    logic [2:0]  waddrA, waddrD;
    logic [47:0] wdataA, wdataD;
    logic [7:0]  pendA, pendD;
    logic [2:0]  count;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_bank(mem_bank),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_bank(alu_bank),
        .alu_addr(alu_addr), .alu_data(alu_data),
        .weA(weA), .waddrA(waddrA), .wdataA(wdataA),
        .weD(weD), .waddrD(waddrD), .wdataD(wdataD),
        .pendA(pendA), .pendD(pendD), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bank;
        logic [2:0]  addr;
        logic [47:0] data;
    } ent_t;

    ent_t        q[$];
    logic [47:0] mA [8];
    logic [47:0] mD [8];
    logic [47:0] shA [8];
    logic [47:0] shD [8];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model.
    task automatic cyc(input bit r, input bit mv, input bit mb, input logic [2:0] ma,
                       input logic [47:0] md, input bit av, input bit ab,
                       input logic [2:0] aa, input logic [47:0] ad);
        int   fr;
        bit   emr, ear, mf, af, wv, bm, ba, ewa, ewd;
        ent_t w;
        logic [7:0] epa, epd;
        @(negedge clk);
        rst = r; mem_valid = mv; mem_bank = mb; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_bank = ab; alu_addr = aa; alu_data = ad;
        #1;
        fr  = DEPTH - q.size();
        emr = !r && fr >= 1;
        ear = !r && (fr >= 2 || (fr >= 1 && !mv));
        chk("mem_ready", mem_ready, emr);
        chk("alu_ready", alu_ready, ear);
        mf = mv && emr;
        af = av && ear;
        wv = 0; bm = 0; ba = 0; w = '0;
        if (!r) begin
            if (q.size() > 0) begin
                w = q[0]; wv = 1;
            end
`ifdef WBQ_BYPASS_EN
            else if (mf) begin
                w = {mb, ma, md}; wv = 1; bm = 1;
            end else if (af) begin
                w = {ab, aa, ad}; wv = 1; ba = 1;
            end
`endif
        end
        ewa = wv && !w.bank && w.addr != 0;
        ewd = wv && w.bank;
        chk("weA", weA, ewa);
        chk("waddrA", waddrA, ewa ? w.addr : 3'd0);
        chk("wdataA", wdataA, ewa ? w.data : 48'd0);
        chk("weD", weD, ewd);
        chk("waddrD", waddrD, ewd ? w.addr : 3'd0);
        chk("wdataD", wdataD, ewd ? w.data : 48'd0);
        epa = '0; epd = '0;
        if (!r) begin
            foreach (q[k]) begin
                if (q[k].bank) epd[q[k].addr] = 1'b1;
                else if (q[k].addr != 0) epa[q[k].addr] = 1'b1;
            end
            chk("count", count, q.size());
        end
        chk("pendA", pendA, epa);
        chk("pendD", pendD, epd);
        if (weA) shA[waddrA] = wdataA;
        if (weD) shD[waddrD] = wdataD;
        if (ewa) mA[w.addr] = w.data;
        if (ewd) mD[w.addr] = w.data;
        if (r) q.delete();
        else begin
            if (q.size() > 0) void'(q.pop_front());
            if (mf && !bm) q.push_back({mb, ma, md});
            if (af && !ba) q.push_back({ab, aa, ad});
        end
    endtask

    task automatic idle(input bit r);
        cyc(r, 0, 0, 3'd0, 48'd0, 0, 0, 3'd0, 48'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) idle(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rnd;
        logic [47:0] d1, d2;
        for (int i = 0; i < 8; i++) begin
            mA[i] = '0; mD[i] = '0; shA[i] = '0; shD[i] = '0;
        end

        // Reset with both producers offering
        cyc(1, 1, 0, 3'd1, 48'h1, 1, 1, 3'd2, 48'h2);
        cyc(1, 1, 0, 3'd1, 48'h1, 1, 1, 3'd2, 48'h2);
        chk("rst_count", count, 0);
        chk("rst_mready", mem_ready, 0);
        idle(0);
        chk("rel_mready", mem_ready, 1);
        chk("rel_aready", alu_ready, 1);

`ifndef WBQ_BYPASS_EN
        // Single write, retires next cycle
        cyc(0, 1, 1, 3'd5, 48'h123456789ABC, 0, 0, 3'd0, 48'd0);
        idle(0);
        chk("single_weD", weD, 1);
        chk("single_waddrD", waddrD, 5);
        chk("single_wdataD", wdataD, 48'h123456789ABC);
        chk("single_pendD", pendD, 8'h20);
        idle(0);
        chk("single_pendD_clr", pendD, 0);

        // Same-register dual hand-off: mem older, alu value lands last
        cyc(0, 1, 0, 3'd3, 48'd1, 1, 0, 3'd3, 48'd2);
        idle(0);
        chk("dual_cnt", count, 2);
        chk("dual_wd1", wdataA, 48'd1);
        idle(0);
        chk("dual_wd2", wdataA, 48'd2);
        idle(0);
        chk("dual_reg", shA[3], 48'd2);

        // Fill: with one retire per cycle the count tops out at DEPTH-1
        cyc(0, 1, 0, 3'd1, 48'hA1, 1, 1, 3'd1, 48'hB1);
        cyc(0, 1, 0, 3'd2, 48'hA2, 1, 1, 3'd2, 48'hB2);
        cyc(0, 1, 1, 3'd3, 48'hA3, 1, 1, 3'd4, 48'hB3);
        chk("fill_cnt", count, 3);
        chk("fill_aready", alu_ready, 0);
        chk("fill_mready", mem_ready, 1);
        drain();

        // A-bank r0 never writes nor pends
        cyc(0, 0, 0, 3'd0, 48'd0, 1, 0, 3'd0, 48'hDEAD);
        idle(0);
        chk("r0_weA", weA, 0);
        chk("r0_pendA", pendA, 0);
        chk("r0_cnt", count, 1);
        idle(0);
        chk("r0_cnt0", count, 0);
`endif

        // Reset mid-operation with three entries queued
        for (int i = 0; i < 6 && q.size() < 3; i++)
            cyc(0, 1, 1, 3'd6, 48'hC0 + 48'(i), 1, 0, 3'd7, 48'hD0 + 48'(i));
        idle(1);
        chk("mid_cnt3", count, 3);
        chk("mid_weA", weA, 0);
        chk("mid_weD", weD, 0);
        idle(0);
        chk("mid_cnt0", count, 0);

`ifdef WBQ_BYPASS_EN
        cyc(0, 1, 1, 3'd2, 48'h55, 0, 0, 3'd0, 48'd0);
        chk("byp_weD", weD, 1);
        chk("byp_waddrD", waddrD, 2);
        idle(0);
        chk("byp_cnt", count, 0);
`endif

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            rnd = {$urandom, $urandom};
            d1 = rnd[47:0];
            rnd = {$urandom, $urandom};
            d2 = rnd[47:0];
            cyc(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), d1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), d2);
        end
        drain();
        chk("end_cnt", count, 0);
        for (int i = 0; i < 8; i++) begin
            chk("regA", shA[i], mA[i]);
            chk("regD", shD[i], mD[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
